// File: rtl/mvu_weight_streamer_if.sv
// AXI-stream style weight beat bundle.
// Master drives data/valid, slave drives ready.
interface mvu_weight_streamer_if #(
  parameter int W = 8
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/mvu_weight_streamer.sv
// Replays the NF x SF weight tile sequence from a
// fixed-latency memory through a credit-based prefetch FIFO.
module mvu_weight_streamer #(
  parameter int MW           = 96,
  parameter int MH           = 32,
  parameter int SIMD         = 48,
  parameter int PE           = 16,
  parameter int WEIGHT_WIDTH = 4,
  parameter int MEM_LATENCY  = 2,
  parameter int FIFO_DEPTH   = MEM_LATENCY + 2,
  localparam int SF    = MW / SIMD,
  localparam int NF    = MH / PE,
  localparam int DEPTH = NF * SF,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int WW    = PE * SIMD * WEIGHT_WIDTH,
  localparam int WW_BA = (WW + 7) / 8 * 8
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic          start,
  input  logic [15:0]   num_images,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [WW-1:0] mem_rd_data,
  mvu_weight_streamer_if.master m_axis_weights
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]          addr;
  logic [15:0]            img;
  logic [15:0]            img_last_q;
  logic [MEM_LATENCY-1:0] tag;
  logic [OW-1:0]          outst;
  logic [CW-1:0]          fifo_cnt;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [WW-1:0]          fifo_q [FIFO_DEPTH];

  logic          push;
  logic          pop;
  logic          fifo_nonempty;
  logic          start_ok;
  logic          credit_ok;
  logic          issue;
  logic          wrap;
  logic          last_rd;
  logic          drain_ok;
  logic [AW-1:0] addr_cur;
  logic [15:0]   img_cur;
  logic [15:0]   img_last;

  // Issue side: the first read goes out in the start cycle itself.
  always_comb begin
    fifo_nonempty = (fifo_cnt != '0);
    push      = tag[MEM_LATENCY-1];
    pop       = fifo_nonempty && m_axis_weights.tready;
    start_ok  = (state == S_IDLE) && start && (num_images != 16'd0);
    credit_ok = (int'(outst) + int'(fifo_cnt) - int'(pop)) < FIFO_DEPTH;
    issue     = start_ok || ((state == S_RUN) && credit_ok);
    addr_cur  = (state == S_IDLE) ? '0 : addr;
    img_cur   = (state == S_IDLE) ? 16'd0 : img;
    img_last  = (state == S_IDLE) ? (num_images - 16'd1) : img_last_q;
    wrap      = (addr_cur == AW'(DEPTH - 1));
    last_rd   = issue && wrap && (img_cur == img_last);
    drain_ok  = (outst == '0) &&
                ((fifo_cnt == '0) || ((fifo_cnt == CW'(1)) && pop));
  end

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (num_images == 16'd0) state_nxt = S_FIN;
          else if (last_rd)        state_nxt = S_DRAIN;
          else                     state_nxt = S_RUN;
        end
      end
      S_RUN:   if (last_rd)  state_nxt = S_DRAIN;
      S_DRAIN: if (drain_ok) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control outputs decoded from state and issue.
  always_comb begin
    busy      = (state == S_RUN) || (state == S_DRAIN);
    done      = (state == S_FIN);
    mem_rd_en = issue;
    mem_addr  = addr_cur;
  end

  // Address / image counters; both return to 0 on the final read.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      addr       <= '0;
      img        <= '0;
      img_last_q <= '0;
    end else begin
      if (start_ok) img_last_q <= num_images - 16'd1;
      if (issue) begin
        addr <= wrap ? '0 : addr_cur + AW'(1);
        if (last_rd)   img <= '0;
        else if (wrap) img <= img_cur + 16'd1;
        else           img <= img_cur;
      end
    end
  end

  // In-flight read tags and outstanding count.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tag   <= '0;
      outst <= '0;
    end else begin
      tag   <= (tag << 1) | MEM_LATENCY'(issue);
      outst <= outst + OW'(issue) - OW'(push);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; credits make an unchecked write safe.
  always_ff @(posedge ap_clk) begin
    if (push) fifo_q[wr_ptr] <= mem_rd_data;
  end

  // Stream output from the FIFO head.
  always_comb begin
    m_axis_weights.tvalid = fifo_nonempty;
    m_axis_weights.tdata  = fifo_nonempty ? WW_BA'(fifo_q[rd_ptr]) : '0;
  end

  a_no_overflow: assert property (
    @(posedge ap_clk) disable iff (!ap_rst_n)
    !(push && !pop && (fifo_cnt == CW'(FIFO_DEPTH)))
  );

endmodule

// File: doc/mvu_weight_streamer.md
Name: mvu_weight_streamer

Overview:
- Memory-backed weight sequencer that feeds the s_axis_weights port of an mvu_vvu_axi instance.
- Replays the full NF x SF weight tile sequence from a fixed-latency synchronous weight memory, once per input image, for a programmed image count.
- Hides memory read latency with a credit-controlled prefetch FIFO, so the output can sustain one beat per cycle under continuous tready.

Parameters:
- MW, 96, matrix width (input channels).
- MH, 32, matrix height (output channels).
- SIMD, 48, weights per PE per beat; MW mod SIMD must be 0.
- PE, 16, PEs per beat; MH mod PE must be 0.
- WEIGHT_WIDTH, 4, bits per weight.
- MEM_LATENCY, 2, cycles from mem_rd_en to valid mem_rd_data; range 1..8.
- FIFO_DEPTH, MEM_LATENCY+2, prefetch FIFO entries; must be at least MEM_LATENCY+1.
- Derived values:
  - SF = MW/SIMD
  - NF = MH/PE
  - DEPTH = NF*SF
  - AW = max(1, $clog2(DEPTH))
  - WW = PE*SIMD*WEIGHT_WIDTH
  - WW_BA = (WW+7)/8*8

Ports:
- ap_clk  in  1  clock; all logic is rising-edge.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin a run; sampled only in IDLE.
- num_images  in  16  number of full weight sweeps; latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when a run completes.
- mem_rd_en  out  1  weight memory read strobe.
- mem_addr  out  AW  weight memory word address; word index = nf*SF + sf.
- mem_rd_data  in  WW  memory word, valid exactly MEM_LATENCY cycles after mem_rd_en.
- m_axis_weights_tdata  out  WW_BA  weight beat, zero-padded in the MSBs above WW.
- m_axis_weights_tvalid  out  1  AXI-stream valid.
- m_axis_weights_tready  in  1  AXI-stream ready.

Behaviour:
- Reset (async assert, sync deassert expected externally):
  - busy, done, mem_rd_en, m_axis_weights_tvalid = 0.
  - mem_addr = 0; FIFO empty; all counters 0.
  - In-flight read tags are cleared, so data returning after reset is discarded.
- FSM states:
  - IDLE -> RUN: on start with num_images != 0. Latch num_images; clear the address counter and image counter.
  - IDLE -> DONE: on start with num_images == 0. No memory reads, no beats.
  - RUN -> DRAIN: when the final read is issued, i.e. the one at address DEPTH-1 in image num_images-1.
  - DRAIN -> DONE: when outstanding reads = 0, FIFO is empty, and the last beat has completed its handshake.
  - DONE -> IDLE: unconditionally after one cycle; done = 1 only in the DONE state.
- start while busy is ignored, with no effect on the current run.
- busy = (state != IDLE && state != DONE).
- Read issue:
  - A read is issued in RUN only when outstanding + fifo_count < FIFO_DEPTH, counting in the same cycle a pop that frees a slot.
  - mem_addr increments after each issue and wraps from DEPTH-1 to 0.
  - On wrap, the image counter increments.
- Read tracking: a MEM_LATENCY-deep valid shift register tags each read. A tag reaching the end pushes mem_rd_data into the FIFO.
- FIFO:
  - Write without a full check is legal, because the credit rule guarantees no overflow; an assertion in simulation checks this.
  - Push and pop in the same cycle leave the count unchanged.
- Output:
  - tdata/tvalid are driven from the FIFO head; tvalid = !fifo_empty.
  - Once tvalid is asserted, tdata is stable until tready.
  - No combinational path from tready to tvalid.
- Throughput: with tready held at 1, one beat per cycle after an initial latency of MEM_LATENCY+1 cycles from the cycle start is accepted.
- Beat count: each run emits exactly num_images*DEPTH beats, in order 0..DEPTH-1, repeated.
- Beat order matches the mvu_vvu_axi expectation: nf outer, sf inner.
- DEPTH=1: the address stays 0 and every beat reads word 0.
- num_images = 65535: the image counter is 16 bits wide and compares on equality, with no overflow.

Test Plan:
- MW=96, SIMD=48, MH=32, PE=16 (DEPTH=4), memory word i = i+1, num_images=3, tready=1 -> 12 beats carrying words 1,2,3,4,1,2,3,4,1,2,3,4 back-to-back. First tvalid occurs 3 cycles after start. done pulses once, 1 cycle after the 12th handshake.
- Same configuration, tready random 30% low -> identical 12-beat sequence. tdata stays stable while tvalid=1 and tready=0. FIFO count never exceeds 4 and outstanding reads never exceed 2.
- tready held 0 for 20 cycles after start -> exactly FIFO_DEPTH=4 reads issued, then mem_rd_en stays 0. Releasing tready drains the remainder with no lost or duplicated beat.
- num_images=0 -> done pulses on the cycle after start; busy stays 0; no mem_rd_en; no tvalid.
- ap_rst_n asserted mid-run after beat 5 with 2 reads in flight -> all outputs go to 0 immediately. Late-returning data is not pushed. A new start with num_images=1 then yields exactly words 1..4.
- start re-pulsed during RUN -> ignored: the beat count remains num_images*DEPTH and only one done pulse occurs.
